// File: rtl/demo_sequencer.sv
// ---------------------------------------------------------------------------
// demo_sequencer
//   Frame-rate scene controller for the VGA demo. It steps the pixel pipeline
//   through a fixed timeline of scenes. Song position from the audio track
//   drives the transitions, and a button or debug skip can force an advance.
//   All state and outputs change only on frame_tick, so the pixel pipeline
//   sees values that are constant for a whole frame.
//
// Ports:
//   clk48         in   1  system clock
//   rst_n         in   1  asynchronous active-low reset
//   frame_tick    in   1  one-cycle pulse at the start of each frame
//   songpos       in   8  song position from the audio track
//   kick_frames   in   3  kick envelope frames (widens the scroll step)
//   snare_frames  in   4  snare envelope frames (triggers the flash)
//   skip_req      in   1  one-cycle request to advance to the next scene
//   scene         out  3  BLACK=0 FADE_IN=1 INTRO=2 PLANE=3 TILES=4 FADE_OUT=5
//   starfield_en  out  1  starfield layer enable
//   scroller_en   out  1  sine scroller layer enable
//   plane_en      out  1  3D checker plane enable
//   scope_en      out  1  oscilloscope enable
//   tiles_en      out  1  flashing-tile overlay enable
//   tile_step     out  4  active tile index
//   fade          out  6  global brightness 0..63
//   flash         out  1  full-white flash request
//   scroll_step   out  5  scroller advance per frame
// ---------------------------------------------------------------------------
module demo_sequencer #(
  parameter int FADE_STEP    = 4,
  parameter int FLASH_FRAMES = 4,
  parameter int MIN_DWELL    = 32,
  parameter int BASE_SCROLL  = 12
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [7:0] songpos,
  input  logic [2:0] kick_frames,
  input  logic [3:0] snare_frames,
  input  logic       skip_req,
  output logic [2:0] scene,
  output logic       starfield_en,
  output logic       scroller_en,
  output logic       plane_en,
  output logic       scope_en,
  output logic       tiles_en,
  output logic [3:0] tile_step,
  output logic [5:0] fade,
  output logic       flash,
  output logic [4:0] scroll_step
);

  typedef enum logic [2:0] {
    S_BLACK    = 3'd0,
    S_FADE_IN  = 3'd1,
    S_INTRO    = 3'd2,
    S_PLANE    = 3'd3,
    S_TILES    = 3'd4,
    S_FADE_OUT = 3'd5
  } scene_t;

  localparam logic [5:0] FADE_MAX = 6'd63;

  scene_t     state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [5:0] fade_q, fade_d;
  logic [2:0] flash_cnt_q, flash_cnt_d;
  logic [3:0] snare_prev_q;
  logic       skip_q;
  logic       star_q, star_d;
  logic       scrl_q, scrl_d;
  logic       plane_q, plane_d;
  logic       scope_q, scope_d;
  logic       tiles_q, tiles_d;
  logic [3:0] tile_step_q, tile_step_d;
  logic [4:0] scroll_q, scroll_d;

  // A skip pulse that lands on the tick cycle itself is consumed by that tick.
  logic       skip_now;
  logic       dwell_ok;
  logic [6:0] fade_sum;
  logic [5:0] fade_up;
  logic [5:0] fade_dn;
  logic       snare_rise;
  logic       cur_active;
  logic       nxt_active;

  assign skip_now   = skip_q | skip_req;
  assign dwell_ok   = (dwell_q >= 8'(MIN_DWELL));
  assign fade_sum   = {1'b0, fade_q} + 7'(FADE_STEP);
  assign fade_up    = (fade_sum > 7'(FADE_MAX)) ? FADE_MAX : fade_sum[5:0];
  assign fade_dn    = (fade_q < 6'(FADE_STEP)) ? 6'd0 : fade_q - 6'(FADE_STEP);
  assign snare_rise = (snare_frames != 4'd0) && (snare_prev_q == 4'd0);
  assign cur_active = (state_q == S_PLANE) || (state_q == S_TILES);
  assign nxt_active = (state_d == S_PLANE) || (state_d == S_TILES);

  // -------------------------------------------------------------------------
  // State register. Every field except the skip latch advances only on a
  // frame tick. The skip latch listens on every cycle.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BLACK;
      dwell_q      <= 8'd0;
      fade_q       <= 6'd0;
      flash_cnt_q  <= 3'd0;
      snare_prev_q <= 4'd0;
      skip_q       <= 1'b0;
      star_q       <= 1'b0;
      scrl_q       <= 1'b0;
      plane_q      <= 1'b0;
      scope_q      <= 1'b0;
      tiles_q      <= 1'b0;
      tile_step_q  <= 4'd0;
      scroll_q     <= 5'(BASE_SCROLL);
    end else begin
      if (frame_tick) begin
        state_q      <= state_d;
        dwell_q      <= dwell_d;
        fade_q       <= fade_d;
        flash_cnt_q  <= flash_cnt_d;
        snare_prev_q <= snare_frames;
        star_q       <= star_d;
        scrl_q       <= scrl_d;
        plane_q      <= plane_d;
        scope_q      <= scope_d;
        tiles_q      <= tiles_d;
        tile_step_q  <= tile_step_d;
        scroll_q     <= scroll_d;
        skip_q       <= 1'b0;
      end else if (skip_req) begin
        skip_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: scene timeline, fade ramp and dwell counter.
  // A skip replaces the natural condition rather than adding to it, so a
  // coincident skip and natural transition still advance only one scene.
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fade_d  = fade_q;
    unique case (state_q)
      S_BLACK: begin
        fade_d  = 6'd0;
        state_d = S_FADE_IN;
      end
      S_FADE_IN: begin
        if (skip_now) begin
          fade_d  = FADE_MAX;
          state_d = S_INTRO;
        end else begin
          fade_d = fade_up;
          if (fade_up == FADE_MAX) state_d = S_INTRO;
        end
      end
      S_INTRO: begin
        fade_d = FADE_MAX;
        if (skip_now || (songpos[7:6] != 2'd0 && dwell_ok)) state_d = S_PLANE;
      end
      S_PLANE: begin
        if (skip_now || (songpos[7:6] == 2'd3 && dwell_ok)) state_d = S_TILES;
      end
      S_TILES: begin
        if (skip_now || (songpos[7:6] == 2'd0 && dwell_ok)) state_d = S_FADE_OUT;
      end
      S_FADE_OUT: begin
        if (skip_now) begin
          fade_d  = 6'd0;
          state_d = S_BLACK;
        end else begin
          fade_d = fade_dn;
          if (fade_dn == 6'd0) state_d = S_BLACK;
        end
      end
      default: begin
        fade_d  = 6'd0;
        state_d = S_BLACK;
      end
    endcase

    if (state_d != state_q) dwell_d = 8'd0;
    else if (dwell_q == 8'hFF) dwell_d = dwell_q;
    else dwell_d = dwell_q + 8'd1;
  end

  // -------------------------------------------------------------------------
  // Output logic. This block decodes the scene being entered, so the outputs
  // registered on a tick already match the new scene. FADE_OUT keeps the
  // layers of the scene it left and drops only the tile overlay.
  // -------------------------------------------------------------------------
  always_comb begin
    star_d      = star_q;
    scrl_d      = scrl_q;
    plane_d     = plane_q;
    scope_d     = scope_q;
    tiles_d     = tiles_q;
    tile_step_d = tile_step_q;
    flash_cnt_d = 3'd0;
    scroll_d    = 5'(BASE_SCROLL);

    unique case (state_d)
      S_FADE_IN, S_INTRO: begin
        star_d  = 1'b1;
        scrl_d  = 1'b1;
        plane_d = 1'b0;
        scope_d = 1'b0;
        tiles_d = 1'b0;
      end
      S_PLANE: begin
        star_d  = 1'b1;
        scrl_d  = 1'b1;
        plane_d = 1'b1;
        scope_d = 1'b1;
        tiles_d = 1'b0;
      end
      S_TILES: begin
        star_d      = 1'b1;
        scrl_d      = 1'b1;
        plane_d     = 1'b1;
        scope_d     = 1'b1;
        tiles_d     = 1'b1;
        tile_step_d = songpos[3:0];
      end
      S_FADE_OUT: begin
        tiles_d = 1'b0;
      end
      default: begin
        star_d  = 1'b0;
        scrl_d  = 1'b0;
        plane_d = 1'b0;
        scope_d = 1'b0;
        tiles_d = 1'b0;
      end
    endcase

    // A flash can only start from a snare onset seen while already in
    // PLANE/TILES. Any tick that leaves those scenes clears the counter.
    if (nxt_active) begin
      scroll_d = 5'(BASE_SCROLL) + {2'b00, kick_frames};
      if (cur_active && snare_rise) flash_cnt_d = 3'(FLASH_FRAMES);
      else if (flash_cnt_q != 3'd0) flash_cnt_d = flash_cnt_q - 3'd1;
    end
  end

  assign scene        = state_q;
  assign starfield_en = star_q;
  assign scroller_en  = scrl_q;
  assign plane_en     = plane_q;
  assign scope_en     = scope_q;
  assign tiles_en     = tiles_q;
  assign tile_step    = tile_step_q;
  assign fade         = fade_q;
  assign flash        = (flash_cnt_q != 3'd0);
  assign scroll_step  = scroll_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_demo_sequencer
//   Directed bench for demo_sequencer. Each task drives one scenario and
//   compares the outputs against hand-computed values. The bench drives
//   inputs on the falling edge and samples outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_demo_sequencer;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [7:0] songpos;
  logic [2:0] kick_frames;
  logic [3:0] snare_frames;
  logic       skip_req;
  logic [2:0] scene;
  logic       starfield_en, scroller_en, plane_en, scope_en, tiles_en;
  logic [3:0] tile_step;
  logic [5:0] fade;
  logic       flash;
  logic [4:0] scroll_step;

  int vectors    = 0;
  int miscompares = 0;

  demo_sequencer dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .songpos      (songpos),
    .kick_frames  (kick_frames),
    .snare_frames (snare_frames),
    .skip_req     (skip_req),
    .scene        (scene),
    .starfield_en (starfield_en),
    .scroller_en  (scroller_en),
    .plane_en     (plane_en),
    .scope_en     (scope_en),
    .tiles_en     (tiles_en),
    .tile_step    (tile_step),
    .fade         (fade),
    .flash        (flash),
    .scroll_step  (scroll_step)
  );

  always #10 clk48 = ~clk48;

  // One frame tick, optionally carrying a skip request in the same cycle.
  task automatic tick(input logic skip);
    @(negedge clk48);
    frame_tick = 1'b1;
    skip_req   = skip;
    @(posedge clk48);
    #1;
    frame_tick = 1'b0;
    skip_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_tick = 1'b0; skip_req = 1'b0;
    songpos = 8'h40; kick_frames = 3'd0; snare_frames = 4'd0;
    idle(3);
    vectors++; if (scene !== 3'd0) begin miscompares++; $display("FAIL reset_scene got %0d want 0", scene); end
    vectors++; if (fade !== 6'd0) begin miscompares++; $display("FAIL reset_fade got %0d want 0", fade); end
    vectors++; if ({starfield_en, scroller_en, plane_en, scope_en, tiles_en} !== 5'b0)
      begin miscompares++; $display("FAIL reset_enables got %b want 00000", {starfield_en, scroller_en, plane_en, scope_en, tiles_en}); end
    vectors++; if (flash !== 1'b0 || tile_step !== 4'd0)
      begin miscompares++; $display("FAIL reset_flash_tile got flash=%b tile=%0d want 0/0", flash, tile_step); end
    vectors++; if (scroll_step !== 5'd12) begin miscompares++; $display("FAIL reset_scroll got %0d want 12", scroll_step); end
    @(negedge clk48);
    rst_n = 1'b1;
    idle(3);
    vectors++; if (scene !== 3'd0) begin miscompares++; $display("FAIL reset_hold_no_tick got %0d want 0", scene); end
  endtask

  task automatic test_fade_in;
    tick(1'b0);
    vectors++; if (scene !== 3'd1 || fade !== 6'd0)
      begin miscompares++; $display("FAIL fade_in_entry got scene=%0d fade=%0d want 1/0", scene, fade); end
    vectors++; if (starfield_en !== 1'b1 || scroller_en !== 1'b1 || plane_en !== 1'b0)
      begin miscompares++; $display("FAIL fade_in_enables got star=%b scrl=%b plane=%b want 1/1/0", starfield_en, scroller_en, plane_en); end
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0);
      vectors++; if (scene !== 3'd1 || fade !== 6'(4 * i))
        begin miscompares++; $display("FAIL fade_in_ramp%0d got scene=%0d fade=%0d want 1/%0d", i, scene, fade, 4 * i); end
    end
    tick(1'b0);
    vectors++; if (scene !== 3'd2 || fade !== 6'd63)
      begin miscompares++; $display("FAIL fade_in_sat got scene=%0d fade=%0d want 2/63", scene, fade); end
    vectors++; if (starfield_en !== 1'b1 || plane_en !== 1'b0)
      begin miscompares++; $display("FAIL intro_enables got star=%b plane=%b want 1/0", starfield_en, plane_en); end
  endtask

  task automatic test_intro_dwell;
    for (int i = 1; i <= 32; i++) begin
      tick(1'b0);
      vectors++; if (scene !== 3'd2)
        begin miscompares++; $display("FAIL intro_dwell%0d got scene=%0d want 2", i, scene); end
    end
    tick(1'b0);
    vectors++; if (scene !== 3'd3 || plane_en !== 1'b1 || scope_en !== 1'b1)
      begin miscompares++; $display("FAIL intro_to_plane got scene=%0d plane=%b scope=%b want 3/1/1", scene, plane_en, scope_en); end
    vectors++; if (scroll_step !== 5'd12 || fade !== 6'd63)
      begin miscompares++; $display("FAIL plane_entry got scroll=%0d fade=%0d want 12/63", scroll_step, fade); end
  endtask

  task automatic test_no_tick_hold;
    @(negedge clk48);
    songpos = 8'hC0; kick_frames = 3'd7;
    idle(10);
    vectors++; if (scene !== 3'd3 || scroll_step !== 5'd12)
      begin miscompares++; $display("FAIL no_tick_hold got scene=%0d scroll=%0d want 3/12", scene, scroll_step); end
    @(negedge clk48);
    songpos = 8'h40; kick_frames = 3'd0;
  endtask

  task automatic test_flash;
    logic [3:0] snare_seq [6] = '{4'd0, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0};
    logic       flash_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      snare_frames = snare_seq[i];
      tick(1'b0);
      vectors++; if (flash !== flash_exp[i])
        begin miscompares++; $display("FAIL flash_tick%0d got %b want %b", i + 1, flash, flash_exp[i]); end
    end
  endtask

  task automatic test_tiles;
    songpos = 8'hC5; kick_frames = 3'd7;
    for (int i = 1; i <= 26; i++) begin
      tick(1'b0);
      vectors++; if (scene !== 3'd3 || scroll_step !== 5'd19)
        begin miscompares++; $display("FAIL plane_dwell%0d got scene=%0d scroll=%0d want 3/19", i, scene, scroll_step); end
    end
    tick(1'b0);
    vectors++; if (scene !== 3'd4 || tile_step !== 4'd5 || tiles_en !== 1'b1)
      begin miscompares++; $display("FAIL plane_to_tiles got scene=%0d tile=%0d tiles_en=%b want 4/5/1", scene, tile_step, tiles_en); end
    vectors++; if (scroll_step !== 5'd19)
      begin miscompares++; $display("FAIL tiles_scroll got %0d want 19", scroll_step); end
    songpos = 8'hCA;
    tick(1'b0);
    vectors++; if (scene !== 3'd4 || tile_step !== 4'd10)
      begin miscompares++; $display("FAIL tiles_step_follow got scene=%0d tile=%0d want 4/10", scene, tile_step); end
  endtask

  task automatic test_async_reset;
    #4;
    rst_n = 1'b0;
    #1;
    vectors++; if (scene !== 3'd0 || fade !== 6'd0 || tile_step !== 4'd0 || scroll_step !== 5'd12)
      begin miscompares++; $display("FAIL async_reset_vals got scene=%0d fade=%0d tile=%0d scroll=%0d want 0/0/0/12", scene, fade, tile_step, scroll_step); end
    vectors++; if ({starfield_en, scroller_en, plane_en, scope_en, tiles_en, flash} !== 6'b0)
      begin miscompares++; $display("FAIL async_reset_enables got %b want 000000", {starfield_en, scroller_en, plane_en, scope_en, tiles_en, flash}); end
    kick_frames = 3'd0;
    @(negedge clk48);
    rst_n = 1'b1;
    idle(2);
    vectors++; if (scene !== 3'd0)
      begin miscompares++; $display("FAIL async_release got scene=%0d want 0", scene); end
    tick(1'b0);
    vectors++; if (scene !== 3'd1 || fade !== 6'd0)
      begin miscompares++; $display("FAIL async_restart got scene=%0d fade=%0d want 1/0", scene, fade); end
  endtask

  task automatic test_skip_mid_frame;
    repeat (5) tick(1'b0);
    vectors++; if (fade !== 6'd20)
      begin miscompares++; $display("FAIL skip_pre_fade got %0d want 20", fade); end
    @(negedge clk48); skip_req = 1'b1;
    @(negedge clk48); skip_req = 1'b0;
    idle(2);
    vectors++; if (scene !== 3'd1 || fade !== 6'd20)
      begin miscompares++; $display("FAIL skip_no_tick got scene=%0d fade=%0d want 1/20", scene, fade); end
    tick(1'b0);
    vectors++; if (scene !== 3'd2 || fade !== 6'd63)
      begin miscompares++; $display("FAIL skip_advance got scene=%0d fade=%0d want 2/63", scene, fade); end
    tick(1'b0);
    vectors++; if (scene !== 3'd2)
      begin miscompares++; $display("FAIL skip_latch_clear got scene=%0d want 2", scene); end
  endtask

  task automatic test_skip_coincident;
    @(negedge clk48); rst_n = 1'b0;
    @(negedge clk48); rst_n = 1'b1; songpos = 8'h40;
    repeat (16) tick(1'b0);
    vectors++; if (scene !== 3'd1 || fade !== 6'd60)
      begin miscompares++; $display("FAIL coinc_pre got scene=%0d fade=%0d want 1/60", scene, fade); end
    tick(1'b1);
    vectors++; if (scene !== 3'd2 || fade !== 6'd63)
      begin miscompares++; $display("FAIL coinc_single got scene=%0d fade=%0d want 2/63", scene, fade); end
    tick(1'b0);
    vectors++; if (scene !== 3'd2)
      begin miscompares++; $display("FAIL coinc_hold got scene=%0d want 2", scene); end
  endtask

  task automatic test_fade_out;
    songpos = 8'h00; snare_frames = 4'd0;
    tick(1'b1);
    tick(1'b1);
    vectors++; if (scene !== 3'd4 || tile_step !== 4'd0)
      begin miscompares++; $display("FAIL skip_to_tiles got scene=%0d tile=%0d want 4/0", scene, tile_step); end
    snare_frames = 4'd5;
    tick(1'b0);
    vectors++; if (scene !== 3'd4 || flash !== 1'b1)
      begin miscompares++; $display("FAIL tiles_flash got scene=%0d flash=%b want 4/1", scene, flash); end
    snare_frames = 4'd0;
    tick(1'b1);
    vectors++; if (scene !== 3'd5 || fade !== 6'd63 || flash !== 1'b0)
      begin miscompares++; $display("FAIL fade_out_entry got scene=%0d fade=%0d flash=%b want 5/63/0", scene, fade, flash); end
    vectors++; if ({starfield_en, scroller_en, plane_en, scope_en, tiles_en} !== 5'b11110 || scroll_step !== 5'd12)
      begin miscompares++; $display("FAIL fade_out_enables got %b scroll=%0d want 11110/12", {starfield_en, scroller_en, plane_en, scope_en, tiles_en}, scroll_step); end
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0);
      vectors++; if (scene !== 3'd5 || fade !== 6'(63 - 4 * i))
        begin miscompares++; $display("FAIL fade_out_ramp%0d got scene=%0d fade=%0d want 5/%0d", i, scene, fade, 63 - 4 * i); end
    end
    tick(1'b0);
    vectors++; if (scene !== 3'd0 || fade !== 6'd0 || starfield_en !== 1'b0 || plane_en !== 1'b0)
      begin miscompares++; $display("FAIL fade_out_to_black got scene=%0d fade=%0d star=%b plane=%b want 0/0/0/0", scene, fade, starfield_en, plane_en); end
  endtask

  task automatic test_skip_chain;
    logic [2:0] chain [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 5; i++) begin
      tick(i != 0);
      vectors++; if (scene !== chain[i])
        begin miscompares++; $display("FAIL skip_chain%0d got scene=%0d want %0d", i, scene, chain[i]); end
    end
    tick(1'b0);
    vectors++; if (fade !== 6'd59)
      begin miscompares++; $display("FAIL chain_fade_out got %0d want 59", fade); end
    tick(1'b1);
    vectors++; if (scene !== 3'd0 || fade !== 6'd0)
      begin miscompares++; $display("FAIL skip_fade_out got scene=%0d fade=%0d want 0/0", scene, fade); end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_intro_dwell();
    test_no_tick_hold();
    test_flash();
    test_tiles();
    test_async_reset();
    test_skip_mid_frame();
    test_skip_coincident();
    test_fade_out();
    test_skip_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
